// File: rtl/pipe_stage_regs.sv
// PC, IF/ID and ID/EX pipeline registers with stall/flush handling and
// saturating stall/flush event counters.
module pipe_stage_regs #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallF,
    input  logic             stallD,
    input  logic             flushE,
    input  logic             pcsrcD,
    input  logic [31:0]      pc_branchD,
    input  logic [31:0]      instrF,
    input  logic [31:0]      rd1D,
    input  logic [31:0]      rd2D,
    input  logic [31:0]      signimmD,
    input  logic             regwrtD,
    input  logic             mem2regD,
    input  logic             memwrtD,
    input  logic             alusrcD,
    input  logic             regdstD,
    input  logic [2:0]       alucontrolD,
    output logic [31:0]      pcF,
    output logic [31:0]      instrD,
    output logic [31:0]      pcplus4D,
    output logic [4:0]       rsD,
    output logic [4:0]       rtD,
    output logic [4:0]       rdD,
    output logic             validD,
    output logic             validE,
    output logic [31:0]      rd1E,
    output logic [31:0]      rd2E,
    output logic [31:0]      signimmE,
    output logic [4:0]       rsE,
    output logic [4:0]       rtE,
    output logic [4:0]       rdE,
    output logic             regwrtE,
    output logic             mem2regE,
    output logic             memwrtE,
    output logic             alusrcE,
    output logic             regdstE,
    output logic [2:0]       alucontrolE,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] signimm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        regwrt;
        logic        mem2reg;
        logic        memwrt;
        logic        alusrc;
        logic        regdst;
        logic [2:0]  alucontrol;
        logic        valid;
    } ex_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instrD_q, instrD_d;
    logic [31:0]      pcplus4D_q, pcplus4D_d;
    logic             validD_q, validD_d;
    ex_t              ex_q, ex_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             clearD;

    // A taken branch only squashes decode when decode is not being held.
    assign clearD = pcsrcD & ~stallD;

    always_comb begin
        pc_d = pc_q;
        if (!stallF) pc_d = pcsrcD ? pc_branchD : pc_q + 32'd4;

        instrD_d   = instrD_q;
        pcplus4D_d = pcplus4D_q;
        validD_d   = validD_q;
        if (!stallD) begin
            if (pcsrcD) begin
                instrD_d   = 32'd0;
                pcplus4D_d = 32'd0;
                validD_d   = 1'b0;
            end else begin
                instrD_d   = instrF;
                pcplus4D_d = pc_q + 32'd4;
                validD_d   = 1'b1;
            end
        end

        ex_d = '0;
        if (!flushE) begin
            ex_d.rd1        = rd1D;
            ex_d.rd2        = rd2D;
            ex_d.signimm    = signimmD;
            ex_d.rs         = instrD_q[25:21];
            ex_d.rt         = instrD_q[20:16];
            ex_d.rd         = instrD_q[15:11];
            ex_d.regwrt     = regwrtD;
            ex_d.mem2reg    = mem2regD;
            ex_d.memwrt     = memwrtD;
            ex_d.alusrc     = alusrcD;
            ex_d.regdst     = regdstD;
            ex_d.alucontrol = alucontrolD;
            ex_d.valid      = validD_q;
        end

        stall_cnt_d = stallD ? sat_inc(stall_cnt_q) : stall_cnt_q;
        flush_cnt_d = clearD ? sat_inc(flush_cnt_q) : flush_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            instrD_q    <= 32'd0;
            pcplus4D_q  <= 32'd0;
            validD_q    <= 1'b0;
            ex_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            instrD_q    <= instrD_d;
            pcplus4D_q  <= pcplus4D_d;
            validD_q    <= validD_d;
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pcF         = pc_q;
    assign instrD      = instrD_q;
    assign pcplus4D    = pcplus4D_q;
    assign rsD         = instrD_q[25:21];
    assign rtD         = instrD_q[20:16];
    assign rdD         = instrD_q[15:11];
    assign validD      = validD_q;
    assign validE      = ex_q.valid;
    assign rd1E        = ex_q.rd1;
    assign rd2E        = ex_q.rd2;
    assign signimmE    = ex_q.signimm;
    assign rsE         = ex_q.rs;
    assign rtE         = ex_q.rt;
    assign rdE         = ex_q.rd;
    assign regwrtE     = ex_q.regwrt;
    assign mem2regE    = ex_q.mem2reg;
    assign memwrtE     = ex_q.memwrt;
    assign alusrcE     = ex_q.alusrc;
    assign regdstE     = ex_q.regdst;
    assign alucontrolE = ex_q.alucontrol;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Randomized scoreboard bench for pipe_stage_regs against a cycle-level
// reference model of the fetch/decode/execute register rules.
module tb_pipe_stage_regs;

    localparam int          CNT_W    = 4;
    localparam logic [31:0] RESET_PC = 32'h00000000;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [31:0]      pcF;
        logic [31:0]      instrD;
        logic [31:0]      pcplus4D;
        logic [4:0]       rsD;
        logic [4:0]       rtD;
        logic [4:0]       rdD;
        logic             validD;
        logic             validE;
        logic [31:0]      rd1E;
        logic [31:0]      rd2E;
        logic [31:0]      signimmE;
        logic [4:0]       rsE;
        logic [4:0]       rtE;
        logic [4:0]       rdE;
        logic             regwrtE;
        logic             mem2regE;
        logic             memwrtE;
        logic             alusrcE;
        logic             regdstE;
        logic [2:0]       alucontrolE;
        logic [CNT_W-1:0] stall_cnt;
        logic [CNT_W-1:0] flush_cnt;
    } snap_t;

    logic clk, rst;
    logic stallF, stallD, flushE, pcsrcD;
    logic [31:0] pc_branchD, instrF, rd1D, rd2D, signimmD;
    logic regwrtD, mem2regD, memwrtD, alusrcD, regdstD;
    logic [2:0] alucontrolD;
    logic [31:0] pcF, instrD, pcplus4D, rd1E, rd2E, signimmE;
    logic [4:0] rsD, rtD, rdD, rsE, rtE, rdE;
    logic validD, validE, regwrtE, mem2regE, memwrtE, alusrcE, regdstE;
    logic [2:0] alucontrolE;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipe_stage_regs #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD), .flushE(flushE),
        .pcsrcD(pcsrcD), .pc_branchD(pc_branchD), .instrF(instrF),
        .rd1D(rd1D), .rd2D(rd2D), .signimmD(signimmD),
        .regwrtD(regwrtD), .mem2regD(mem2regD), .memwrtD(memwrtD),
        .alusrcD(alusrcD), .regdstD(regdstD), .alucontrolD(alucontrolD),
        .pcF(pcF), .instrD(instrD), .pcplus4D(pcplus4D),
        .rsD(rsD), .rtD(rtD), .rdD(rdD), .validD(validD), .validE(validE),
        .rd1E(rd1E), .rd2E(rd2E), .signimmE(signimmE),
        .rsE(rsE), .rtE(rtE), .rdE(rdE),
        .regwrtE(regwrtE), .mem2regE(mem2regE), .memwrtE(memwrtE),
        .alusrcE(alusrcE), .regdstE(regdstE), .alucontrolE(alucontrolE),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory: a fixed scramble of the address.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    assign instrF = imem(pcF);

    int n_checks = 0;
    int n_fail   = 0;
    snap_t exp_q[$];

    // Reference model state
    logic [31:0] m_pc, m_instrD, m_pc4D;
    logic        m_vD;
    logic [31:0] m_rd1E, m_rd2E, m_immE;
    logic [4:0]  m_rsE, m_rtE, m_rdE;
    logic [4:0]  m_ctlE;
    logic [2:0]  m_aluE;
    logic        m_vE;
    int          m_sc, m_fc;

    function automatic snap_t dut_snap();
        snap_t s;
        s.pcF = pcF; s.instrD = instrD; s.pcplus4D = pcplus4D;
        s.rsD = rsD; s.rtD = rtD; s.rdD = rdD;
        s.validD = validD; s.validE = validE;
        s.rd1E = rd1E; s.rd2E = rd2E; s.signimmE = signimmE;
        s.rsE = rsE; s.rtE = rtE; s.rdE = rdE;
        s.regwrtE = regwrtE; s.mem2regE = mem2regE; s.memwrtE = memwrtE;
        s.alusrcE = alusrcE; s.regdstE = regdstE; s.alucontrolE = alucontrolE;
        s.stall_cnt = stall_cnt; s.flush_cnt = flush_cnt;
        return s;
    endfunction

    function automatic snap_t model_snap();
        snap_t s;
        s.pcF = m_pc; s.instrD = m_instrD; s.pcplus4D = m_pc4D;
        s.rsD = m_instrD[25:21]; s.rtD = m_instrD[20:16]; s.rdD = m_instrD[15:11];
        s.validD = m_vD; s.validE = m_vE;
        s.rd1E = m_rd1E; s.rd2E = m_rd2E; s.signimmE = m_immE;
        s.rsE = m_rsE; s.rtE = m_rtE; s.rdE = m_rdE;
        {s.regwrtE, s.mem2regE, s.memwrtE, s.alusrcE, s.regdstE} = m_ctlE;
        s.alucontrolE = m_aluE;
        s.stall_cnt = CNT_W'(m_sc); s.flush_cnt = CNT_W'(m_fc);
        return s;
    endfunction

    task automatic model_reset();
        m_pc = RESET_PC; m_instrD = 0; m_pc4D = 0; m_vD = 0;
        m_rd1E = 0; m_rd2E = 0; m_immE = 0; m_rsE = 0; m_rtE = 0; m_rdE = 0;
        m_ctlE = 0; m_aluE = 0; m_vE = 0; m_sc = 0; m_fc = 0;
    endtask

    // One rising edge worth of behaviour, from the current inputs.
    task automatic model_edge();
        if (flushE) begin
            m_rd1E = 0; m_rd2E = 0; m_immE = 0; m_rsE = 0; m_rtE = 0; m_rdE = 0;
            m_ctlE = 0; m_aluE = 0; m_vE = 0;
        end else begin
            m_rd1E = rd1D; m_rd2E = rd2D; m_immE = signimmD;
            m_rsE = m_instrD[25:21]; m_rtE = m_instrD[20:16]; m_rdE = m_instrD[15:11];
            m_ctlE = {regwrtD, mem2regD, memwrtD, alusrcD, regdstD};
            m_aluE = alucontrolD; m_vE = m_vD;
        end
        if (stallD && m_sc < CNT_MAX) m_sc++;
        if (!stallD && pcsrcD && m_fc < CNT_MAX) m_fc++;
        if (!stallD) begin
            if (pcsrcD) begin
                m_instrD = 0; m_pc4D = 0; m_vD = 0;
            end else begin
                m_instrD = imem(m_pc); m_pc4D = m_pc + 32'd4; m_vD = 1;
            end
        end
        if (!stallF) m_pc = pcsrcD ? pc_branchD : m_pc + 32'd4;
    endtask

    task automatic compare(input string name, input snap_t act, input snap_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h required %h", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic sF, input logic sD, input logic fE,
                        input logic ps, input logic [31:0] tgt);
        @(negedge clk);
        stallF = sF; stallD = sD; flushE = fE; pcsrcD = ps; pc_branchD = tgt;
        rd1D = $urandom; rd2D = $urandom; signimmD = $urandom;
        {regwrtD, mem2regD, memwrtD, alusrcD, regdstD} = 5'($urandom);
        alucontrolD = 3'($urandom);
        @(posedge clk);
        model_edge();
        exp_q.push_back(model_snap());
    endtask

    // Monitor: each edge that has a prediction queued is checked just after it.
    initial begin
        snap_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                compare("pipe_regs", dut_snap(), e);
            end
        end
    end

    initial begin
        snap_t rst_exp;
        rst = 1'b1;
        stallF = 0; stallD = 0; flushE = 0; pcsrcD = 0; pc_branchD = 0;
        rd1D = 0; rd2D = 0; signimmD = 0;
        {regwrtD, mem2regD, memwrtD, alusrcD, regdstD} = 0; alucontrolD = 0;
        model_reset();
        rst_exp = model_snap();
        #3;
        compare("reset_state", dut_snap(), rst_exp);
        @(posedge clk);
        #2 rst = 1'b0;

        // Clean fetch from reset, reaching pcF=0x10
        repeat (4) step(0, 0, 0, 0, 0);
        // Load-use style stall with bubble
        repeat (2) step(1, 1, 1, 0, 0);
        // Taken branch, then branch masked by stall
        step(0, 0, 0, 1, 32'h40);
        step(1, 1, 0, 1, 32'h99);
        step(0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a stalled branch
        step(1, 1, 0, 0, 0);
        @(negedge clk);
        stallF = 1; stallD = 1; pcsrcD = 1; pc_branchD = 32'h80;
        #2 rst = 1'b1;
        #1 compare("async_reset", dut_snap(), rst_exp);
        model_reset();
        @(posedge clk);
        #1 compare("reset_hold", dut_snap(), rst_exp);
        #1 rst = 1'b0;
        stallF = 0; stallD = 0; pcsrcD = 0; pc_branchD = 0;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Stall counter saturation
        repeat ((1 << CNT_W) + 3) step(1'($urandom), 1, 1'($urandom), 0, 0);

        // PC wrap from the top of the address space
        step(0, 0, 0, 1, 32'hFFFFFFFC);
        repeat (3) step(0, 0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                 {$urandom_range(0, 32'h3FFFFFFF), 2'b00});
        end

        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d predictions left unchecked, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
